serial_transmitter: RTL and testbench

- Transmit half of the full-custom SSP module, built as the counterpart of serial_receiver.
- Pulls bytes from the TX FIFO through a valid/ack handshake. Serialises each byte MSB-first using the same frame format serial_receiver expects: a one-cycle frame-sync pulse, followed by DATA_WIDTH data bits on consecutive clocks.
- Supports back-to-back frames with no idle gap, by overlapping the next frame's sync pulse with the current frame's LSB.

---
 rtl/ssp_pkg.sv | 25 ++
 rtl/ssp_tx_shift.sv | 48 ++++
 rtl/serial_transmitter.sv | 134 +++++++++++++
 tb/tb_serial_transmitter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ssp_pkg.sv
// Shared definitions for the SSP transmit path: FSM encoding, default frame
// width and the bit-counter width helper.
package ssp_pkg;

    localparam int SSP_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_SHIFT = 2'd2
    } ssp_state_e;

    // Smallest width able to index DATA_WIDTH bit positions (at least 1).
    function automatic int ssp_clog2(input int value);
        int r;
        r = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ssp_tx_shift.sv
// Parallel-load / shift-left register with MSB tap and a bit counter that
// flags the LSB cycle and the cycle after it.
module ssp_tx_shift
    import ssp_pkg::*;
#(
    parameter int DATA_WIDTH = SSP_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic                  cnt_clr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  msb,
    output logic                  last_bit,
    output logic                  past_last
);

    localparam int CNT_W = ssp_clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else begin
            if (load) begin
                shreg <= data;
            end else if (shift) begin
                shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
            end

            // A reload on the LSB edge holds the count; the following edge clears it.
            if (cnt_clr) begin
                cnt <= '0;
            end else if (shift) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign msb       = shreg[DATA_WIDTH-1];
    assign last_bit  = (cnt == CNT_W'(DATA_WIDTH - 2));
    assign past_last = (cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/serial_transmitter.sv
// SSP transmit half: pulls words from the TX FIFO and sends them MSB-first
// behind a one-cycle frame-sync pulse, chaining frames without idle gaps.
module serial_transmitter
    import ssp_pkg::*;
#(
    parameter int DATA_WIDTH = SSP_DATA_WIDTH
) (
    input  logic                  sspclkin,
    input  logic                  rst_i,
    input  logic                  sse,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ack,
    output logic                  sspfssout,
    output logic                  ssptxd,
    output logic                  ssp_oe_b,
    output logic                  busy
);

    // Handshake: a word is taken when the FSM samples sse && tx_valid at a
    // rising edge; tx_ack then pulses for exactly one cycle and the FIFO pops
    // on the following edge, so no new capture is allowed while tx_ack is high.

    ssp_state_e state;

    logic start_ok;
    logic sh_load;
    logic sh_shift;
    logic sh_cnt_clr;
    logic sh_msb;
    logic sh_last_bit;
    logic sh_past_last;

    assign start_ok = sse & tx_valid;

    always_comb begin
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
        sh_cnt_clr = 1'b0;
        case (state)
            ST_IDLE: begin
                sh_load = start_ok;
            end
            ST_SYNC: begin
                sh_shift   = 1'b1;
                sh_cnt_clr = 1'b1;
            end
            ST_SHIFT: begin
                // tx_ack high here means the previous edge reloaded a chained frame.
                if (tx_ack) begin
                    sh_shift   = 1'b1;
                    sh_cnt_clr = 1'b1;
                end else if (sh_past_last) begin
                    sh_shift = 1'b0;
                end else if (sh_last_bit && start_ok) begin
                    sh_load = 1'b1;
                end else begin
                    sh_shift = 1'b1;
                end
            end
            default: begin
                sh_load = 1'b0;
            end
        endcase
    end

    ssp_tx_shift #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shift (
        .clk       (sspclkin),
        .rst       (rst_i),
        .load      (sh_load),
        .shift     (sh_shift),
        .cnt_clr   (sh_cnt_clr),
        .data      (tx_data),
        .msb       (sh_msb),
        .last_bit  (sh_last_bit),
        .past_last (sh_past_last)
    );

    always_ff @(posedge sspclkin or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            tx_ack    <= 1'b0;
            sspfssout <= 1'b0;
            ssptxd    <= 1'b0;
            ssp_oe_b  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ssptxd   <= 1'b0;
                    ssp_oe_b <= 1'b1;
                    if (start_ok) begin
                        sspfssout <= 1'b1;
                        tx_ack    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    sspfssout <= 1'b0;
                    tx_ack    <= 1'b0;
                    ssptxd    <= sh_msb;
                    ssp_oe_b  <= 1'b0;
                    state     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    sspfssout <= 1'b0;
                    tx_ack    <= 1'b0;
                    if (tx_ack) begin
                        ssptxd <= sh_msb;
                    end else if (sh_past_last) begin
                        ssptxd   <= 1'b0;
                        ssp_oe_b <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        ssptxd <= sh_msb;
                        // Next frame's sync overlaps the current LSB.
                        if (sh_last_bit && start_ok) begin
                            sspfssout <= 1'b1;
                            tx_ack    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_transmitter.sv
// Bench for serial_transmitter: a FIFO model feeds words, a monitor
// deserialises the line and checks frames against an expected queue.
module tb_serial_transmitter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         sse;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ack;
    logic         sspfssout;
    logic         ssptxd;
    logic         ssp_oe_b;
    logic         busy;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];

    int total = 0;
    int bad   = 0;
    int ack_cnt = 0;
    int fss_cnt = 0;
    int frames_done = 0;
    int overlap_cnt = 0;
    bit mon_active = 1'b0;
    int mon_nbits = 0;
    logic [W-1:0] mon_sh = '0;
    bit prev_ack = 1'b0;

    serial_transmitter #(
        .DATA_WIDTH (W)
    ) dut (
        .sspclkin  (clk),
        .rst_i     (rst_i),
        .sse       (sse),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ack    (tx_ack),
        .sspfssout (sspfssout),
        .ssptxd    (ssptxd),
        .ssp_oe_b  (ssp_oe_b),
        .busy      (busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO model: pops on the negedge after tx_ack, presents the new head.
    initial begin
        tx_valid = 1'b0;
        tx_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_i && tx_ack && fifo_q.size() != 0) begin
                void'(fifo_q.pop_front());
            end
            tx_valid = (fifo_q.size() != 0);
            tx_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        end
    end

    // monitor / scoreboard
    initial begin : monitor
        bit was_active;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                mon_active = 1'b0;
                mon_nbits  = 0;
                prev_ack   = 1'b0;
            end else begin
                was_active = mon_active;
                check("oe_b", int'(ssp_oe_b), int'(!was_active));
                check("busy", int'(busy), int'(was_active | sspfssout));
                check("ack_fss_align", int'(tx_ack), int'(sspfssout));
                check("ack_twice", int'(prev_ack & tx_ack), 0);
                if (!was_active) begin
                    check("txd_idle", int'(ssptxd), 0);
                end
                prev_ack = tx_ack;
                if (tx_ack) ack_cnt++;
                if (was_active) begin
                    mon_sh = {mon_sh[W-2:0], ssptxd};
                    mon_nbits++;
                    if (mon_nbits == W) begin
                        mon_active = 1'b0;
                        frames_done++;
                        check("frame_expected", int'(exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) begin
                            check("frame_data", int'(mon_sh), int'(exp_q.pop_front()));
                        end
                    end
                end
                if (sspfssout) begin
                    if (was_active) overlap_cnt++;
                    fss_cnt++;
                    mon_active = 1'b1;
                    mon_nbits  = 0;
                end
            end
        end
    end

    // driver tasks
    task automatic send(input logic [W-1:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic wait_fss(input int target);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (fss_cnt >= target) break;
        end
        check("fss_seen", int'(fss_cnt >= target), 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (fifo_q.size() == 0 && exp_q.size() == 0 && !mon_active && busy == 1'b0) break;
        end
        check("drain_exp", exp_q.size(), 0);
        check("drain_busy", int'(busy), 0);
    endtask

    initial begin : stimulus
        int a0;
        int f0;
        int d0;
        int o0;
        rst_i = 1'b1;
        sse   = 1'b0;
        #20;
        check("rst_ack", int'(tx_ack), 0);
        check("rst_fss", int'(sspfssout), 0);
        check("rst_txd", int'(ssptxd), 0);
        check("rst_oe_b", int'(ssp_oe_b), 1);
        check("rst_busy", int'(busy), 0);
        #32;
        rst_i = 1'b0;

        // single frame 0xA5
        @(negedge clk);
        #1;
        sse = 1'b1;
        a0 = ack_cnt;
        d0 = frames_done;
        send(8'hA5);
        wait_idle();
        check("single_acks", ack_cnt - a0, 1);
        check("single_frames", frames_done - d0, 1);

        // back-to-back 0x3C, 0xC3
        a0 = ack_cnt;
        o0 = overlap_cnt;
        send(8'h3C);
        send(8'hC3);
        wait_idle();
        check("b2b_acks", ack_cnt - a0, 2);
        check("b2b_overlap", overlap_cnt - o0, 1);

        // sse low with data waiting
        sse = 1'b0;
        a0 = ack_cnt;
        f0 = fss_cnt;
        send(8'h11);
        repeat (20) @(negedge clk);
        #1;
        check("gate_acks", ack_cnt - a0, 0);
        check("gate_fss", fss_cnt - f0, 0);
        check("gate_busy", int'(busy), 0);
        sse = 1'b1;
        wait_idle();

        // sse dropped mid-frame of 0xFF
        a0 = ack_cnt;
        d0 = frames_done;
        f0 = fss_cnt;
        send(8'hFF);
        send(8'h77);
        wait_fss(f0 + 1);
        repeat (3) @(negedge clk);
        sse = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        check("drop_acks", ack_cnt - a0, 1);
        check("drop_frames", frames_done - d0, 1);
        check("drop_fifo_left", fifo_q.size(), 1);
        check("drop_busy", int'(busy), 0);
        sse = 1'b1;
        wait_idle();

        // reset mid-frame of 0x96
        f0 = fss_cnt;
        send(8'h96);
        wait_fss(f0 + 1);
        repeat (4) @(negedge clk);
        #2;
        rst_i = 1'b1;
        #1;
        check("mid_rst_ack", int'(tx_ack), 0);
        check("mid_rst_fss", int'(sspfssout), 0);
        check("mid_rst_txd", int'(ssptxd), 0);
        check("mid_rst_oe_b", int'(ssp_oe_b), 1);
        check("mid_rst_busy", int'(busy), 0);
        exp_q.delete();
        fifo_q.delete();
        @(negedge clk);
        #3;
        rst_i = 1'b0;
        a0 = ack_cnt;
        repeat (3) @(negedge clk);
        #1;
        check("post_rst_no_ack", ack_cnt - a0, 0);
        send(8'h5A);
        wait_idle();

        // loopback-style pair 0x5A then 0x81
        d0 = frames_done;
        send(8'h5A);
        wait_idle();
        send(8'h81);
        wait_idle();
        check("loop_frames", frames_done - d0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
